player_cmd_issuer: RTL
======================

Name: player_cmd_issuer

Overview:
- Producer end of the 16-bit player instruction bus: turns game-logic requests (movement, heal, damage, attack changes, HP set) into instruction words for the player block.
- Frames each word to match how the player samples it:
  - stat ops are evaluated on every `clk` edge, so they are presented for exactly one cycle;
  - moves are evaluated only on the 10 Hz edge, so they are held until that edge has passed.
- Sits between the game/collision logic and the player.

Parameters:
- FIFO_DEPTH, 4, entries in the stat-request queue (power of 2, ≥2).
- MOVE_TIMEOUT, 10000000, `clk` cycles a move is held without `slow_edge` before abort.
- TMR_W, 24, width of the hold timer (must hold MOVE_TIMEOUT-1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- slow_edge  in  1  one-cycle `clk` pulse asserted in the cycle after each clk_10hz rising edge
- move_valid  in  1  move request
- move_dir  in  2  0 up, 1 left, 2 down, 3 right
- move_ready  out  1  move accepted when valid&ready
- stat_valid  in  1  stat request
- stat_op  in  3  opcode: 1 heal, 2 damage, 3 atk add, 4 atk set, 6 hp set
- stat_arg  in  8  operand
- stat_ready  out  1  queue not full
- instruction  out  16  [15:12] opcode, [11:4] operand, [3:0] zero; registered
- busy  out  1  state≠IDLE or queue non-empty
- err_drop  out  1  one-cycle pulse: illegal stat_op discarded
- move_timeout  out  1  one-cycle pulse: move aborted

Behaviour:
- Reset (async, rst_n low):
  - instruction=0x0000 (NOP); err_drop=0; move_timeout=0.
  - Queue emptied; state IDLE; timer=0.
  - Takes effect mid-move or mid-stat immediately; no partial word survives.
- States: IDLE, STAT, MOVE_HOLD.
- stat_ready = queue not full, independent of state.
- Stat push: on stat_valid&stat_ready.
  - stat_op ∈ {1,2,3,4,6}: write {stat_op, stat_arg} to the queue.
  - Any other value: no write; err_drop pulses the next cycle.
- move_ready = (state==IDLE) & queue empty. Stat requests have strict priority over moves.
- IDLE with queue non-empty, at the clock edge:
  - pop; instruction←{0,op,arg,4'h0}; go to STAT.
- STAT: at the next edge instruction←0x0000; go to IDLE.
  - Every stat word is visible for exactly one cycle and is followed by at least one NOP cycle.
  - Maximum rate is one stat word per 2 cycles.
- Stat latency: a push into an empty queue while IDLE shows the word 2 cycles after the handshake cycle.
- IDLE, queue empty, move_valid, at the clock edge:
  - instruction←{4'h5, 6'b0, move_dir, 4'h0}; timer←0; go to MOVE_HOLD.
  - The word is visible the cycle after the handshake.
- MOVE_HOLD:
  - Word held constant; stat pushes still queue, up to full.
  - slow_edge sampled high: instruction←0, go to IDLE (the word was stable across the 10 Hz edge).
  - Otherwise, timer==MOVE_TIMEOUT-1: instruction←0, move_timeout pulse, go to IDLE.
  - Otherwise timer++.
  - A slow_edge arriving in the same cycle as move acceptance is ignored; a full 10 Hz period is awaited.
- Queue full plus push in the same cycle as a pop: stat_ready reflects the pre-pop occupancy (no bypass).
- Simultaneous push to an empty queue and IDLE: the pop happens the next cycle (no bypass).
- Pointers wrap modulo FIFO_DEPTH; the count is FIFO_DEPTH+1 states wide.

Decomposition:
- Package player_cmd_pkg:
  - opcode constants OP_NOP=0, OP_HEAL=1, OP_DMG=2, OP_ATK_ADD=3, OP_ATK_SET=4, OP_MOVE=5, OP_HP_SET=6;
  - direction constants DIR_UP=0, DIR_LEFT=1, DIR_DOWN=2, DIR_RIGHT=3;
  - field positions;
  - a function building an instruction word from opcode and operand.
- Sub-module: cmd_fifo, a synchronous 11-bit-wide FIFO with full/empty flags and async active-low reset. The issuer FSM and timer stay in the top.

Test Plan:
- Reset → instruction 0x0000, move_ready=1, stat_ready=1, busy=0. Hold rst_n low for 3 cycles mid-MOVE_HOLD → instruction 0x0000 immediately; queue empty after release.
- stat_op=1, arg=0x14, one-cycle handshake → instruction 0x1140 exactly 2 cycles later for 1 cycle, then 0x0000; busy falls.
- move_dir=3 accepted → 0x5030 held for 50 cycles with no slow_edge; slow_edge pulse → 0x0000 the cycle after the pulse; move_ready returns high.
- During a move hold, push damage args 5,6,7,8 → stat_ready=0 after the 4th. After slow_edge the words 0x2050, 0x2060, 0x2070, 0x2080 appear, each one cycle, separated by single NOP cycles. A move_valid held meanwhile is accepted only after the last pop.
- stat_op=5 or 7 → err_drop single pulse; queue count unchanged; instruction stays 0x0000.
- MOVE_TIMEOUT=8, move_dir=0, no slow_edge → 0x5000 for 8 cycles, then 0x0000 with a move_timeout pulse.

Source files
------------

// File: rtl/player_cmd_pkg.sv
// -----------------------------------------------------------------------------
// player_cmd_pkg
// Shared definitions for the player instruction-bus producer:
//   - opcode and direction constants of the 16-bit player instruction word
//   - field positions of the word ([15:12] opcode, [11:4] operand, [3:0] zero)
//   - issuer FSM state encoding
//   - helpers to build a word and to classify stat opcodes
// -----------------------------------------------------------------------------
package player_cmd_pkg;

   localparam int INSTR_W = 16;
   localparam int OP_W    = 4;
   localparam int ARG_W   = 8;
   localparam int ENTRY_W = 11;  // queued stat entry: {op[2:0], arg[7:0]}

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int ARG_MSB = 11;
   localparam int ARG_LSB = 4;

   localparam logic [3:0] OP_NOP     = 4'd0;
   localparam logic [3:0] OP_HEAL    = 4'd1;
   localparam logic [3:0] OP_DMG     = 4'd2;
   localparam logic [3:0] OP_ATK_ADD = 4'd3;
   localparam logic [3:0] OP_ATK_SET = 4'd4;
   localparam logic [3:0] OP_MOVE    = 4'd5;
   localparam logic [3:0] OP_HP_SET  = 4'd6;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_LEFT  = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   localparam logic [15:0] INSTR_NOP = 16'h0000;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_STAT      = 2'd1,
      ST_MOVE_HOLD = 2'd2
   } issuer_state_e;

   // Assemble an instruction word; the low nibble is always zero.
   function automatic logic [15:0] build_instr(input logic [3:0] op,
                                               input logic [7:0] arg);
      logic [15:0] w;
      w                  = INSTR_NOP;
      w[OP_MSB:OP_LSB]   = op;
      w[ARG_MSB:ARG_LSB] = arg;
      return w;
   endfunction

   // True for opcodes the player evaluates every clk edge (heal, damage,
   // attack add/set, hp set). NOP and MOVE are not valid stat requests.
   function automatic logic is_stat_op(input logic [2:0] op);
      logic ok;
      case (op)
         3'd1, 3'd2, 3'd3, 3'd4, 3'd6: ok = 1'b1;
         default:                      ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
// Synchronous FIFO holding pending stat requests. Flags come from the
// registered occupancy only, so a push while full is refused even when a pop
// happens in the same cycle, and a pushed entry is poppable one cycle later.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push_i, wdata_i   write request and data (ignored when full)
//   pop_i             read request (ignored when empty)
//   rdata_o           head entry (valid when !empty_o)
//   full_o, empty_o   occupancy flags
// -----------------------------------------------------------------------------
module cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full_o    = (cnt_q == CNT_W'(DEPTH));
   assign empty_o   = (cnt_q == {CNT_W{1'b0}});
   assign push_ok_s = push_i & ~full_o;
   assign pop_ok_s  = pop_i & ~empty_o;
   assign rdata_o   = mem_q[rd_ptr_q];

   // Next occupancy from the accepted push/pop pair.
   always_comb begin
      cnt_d = cnt_q;
      case ({push_ok_s, pop_ok_s})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Storage write; contents need no reset because the count gates reads.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/player_cmd_issuer.sv
// -----------------------------------------------------------------------------
// player_cmd_issuer
// Producer end of the 16-bit player instruction bus. Stat requests are queued
// and emitted one clk cycle each, always followed by a NOP cycle, because the
// player evaluates them every clk edge. Moves are only evaluated on the 10 Hz
// edge, so a move word is held until slow_edge has been seen (or a timeout).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   slow_edge                  pulse in the cycle after each clk_10hz rise
//   move_valid/move_dir        move request, move_ready handshake
//   stat_valid/stat_op/arg     stat request, stat_ready = queue not full
//   instruction                registered instruction word
//   busy                       not idle or requests pending
//   err_drop                   pulse: illegal stat_op discarded
//   move_timeout               pulse: move aborted without slow_edge
// -----------------------------------------------------------------------------
module player_cmd_issuer
   import player_cmd_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int MOVE_TIMEOUT = 10000000,
   parameter int TMR_W        = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        slow_edge,
   input  logic        move_valid,
   input  logic [1:0]  move_dir,
   output logic        move_ready,
   input  logic        stat_valid,
   input  logic [2:0]  stat_op,
   input  logic [7:0]  stat_arg,
   output logic        stat_ready,
   output logic [15:0] instruction,
   output logic        busy,
   output logic        err_drop,
   output logic        move_timeout
);

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MOVE_TIMEOUT - 1);

   issuer_state_e      state_q;
   logic [15:0]        instr_q;
   logic [TMR_W-1:0]   timer_q;
   logic               move_timeout_q;
   logic               err_drop_q;

   logic               fifo_full_s;
   logic               fifo_empty_s;
   logic [ENTRY_W-1:0] fifo_head_s;
   logic               stat_fire_s;
   logic               stat_push_s;
   logic               stat_pop_s;

   assign stat_ready  = ~fifo_full_s;
   assign stat_fire_s = stat_valid & ~fifo_full_s;
   assign stat_push_s = stat_fire_s & is_stat_op(stat_op);
   // Stats have strict priority: pop whenever idle with anything queued.
   assign stat_pop_s  = (state_q == ST_IDLE) & ~fifo_empty_s;
   assign move_ready  = (state_q == ST_IDLE) & fifo_empty_s;

   assign instruction  = instr_q;
   assign move_timeout = move_timeout_q;
   assign err_drop     = err_drop_q;
   assign busy         = (state_q != ST_IDLE) | ~fifo_empty_s;

   cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_cmd_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (stat_push_s),
      .wdata_i ({stat_op, stat_arg}),
      .pop_i   (stat_pop_s),
      .rdata_o (fifo_head_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s)
   );

   // Flag an accepted stat request whose opcode is not a stat op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_drop_q <= 1'b0;
      end else begin
         err_drop_q <= stat_fire_s & ~is_stat_op(stat_op);
      end
   end

   // Issuer FSM: word framing, move hold timer and timeout pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         instr_q        <= INSTR_NOP;
         timer_q        <= {TMR_W{1'b0}};
         move_timeout_q <= 1'b0;
      end else begin
         move_timeout_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty_s) begin
                  instr_q <= build_instr({1'b0, fifo_head_s[10:8]}, fifo_head_s[7:0]);
                  state_q <= ST_STAT;
               end else if (move_valid) begin
                  instr_q <= build_instr(OP_MOVE, {6'b000000, move_dir});
                  timer_q <= {TMR_W{1'b0}};
                  state_q <= ST_MOVE_HOLD;
               end else begin
                  instr_q <= INSTR_NOP;
               end
            end
            ST_STAT: begin
               // Exactly one cycle of stat word, then a guaranteed NOP cycle.
               instr_q <= INSTR_NOP;
               state_q <= ST_IDLE;
            end
            ST_MOVE_HOLD: begin
               // slow_edge in the acceptance cycle is never seen here, so a
               // full 10 Hz period is always spanned by the held word.
               if (slow_edge) begin
                  instr_q <= INSTR_NOP;
                  state_q <= ST_IDLE;
               end else if (timer_q == TMR_LAST) begin
                  instr_q        <= INSTR_NOP;
                  move_timeout_q <= 1'b1;
                  state_q        <= ST_IDLE;
               end else begin
                  timer_q <= timer_q + TMR_W'(1);
               end
            end
            default: begin
               instr_q <= INSTR_NOP;
               timer_q <= {TMR_W{1'b0}};
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
